// File: rtl/ddr_rd_ctrl.sv
// DDR read controller: splits a beat-count read request into AXI read bursts of at most
// MAX_BURST beats and forwards the returned data one cycle later.
module ddr_rd_ctrl #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DQ_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    init_done,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  output logic                    ddr_rrdy,
  output logic                    ddr_rdone,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic                    rd_err,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  localparam int unsigned DW = 8 * DQ_WIDTH;
  localparam int unsigned BW = 9;  // holds 1..256 beats

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [BW-1:0]         burst_len_q, burst_len_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]         burst_beats;
  logic [DW-1:0]         rdata_q;
  logic                  rdata_en_q;
  logic                  rd_err_q, rd_err_d;
  logic                  accept, beat, burst_end;

  assign ddr_rrdy  = ddr_rstn & init_done & (state_q == StIdle);
  assign accept    = ddr_rreq & ddr_rrdy;
  assign beat      = axi_rvalid & (state_q == StData);
  // The beat counter, not axi_rlast, defines the end of a burst.
  assign burst_end = beat & (beat_cnt_q == burst_len_q - BW'(1));

  always_comb begin
    if (remaining_q >= LEN_WIDTH'(MAX_BURST)) begin
      burst_beats = BW'(MAX_BURST);
    end else begin
      burst_beats = BW'(remaining_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    rd_err_d    = rd_err_q | (axi_rvalid & (state_q != StData)) | (beat & (axi_rlast != burst_end));
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cur_addr_d  = ddr_raddr;
          remaining_d = ddr_rd_len;
          state_d     = (ddr_rd_len != '0) ? StAddr : StDone;
        end
      end
      StAddr: begin
        if (axi_arready) begin
          burst_len_d = burst_beats;
          beat_cnt_d  = '0;
          state_d     = StData;
        end
      end
      StData: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (burst_end) begin
            remaining_d = remaining_q - LEN_WIDTH'(burst_len_q);
            cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(burst_len_q) << 3);
            state_d     = (remaining_d != '0) ? StAddr : StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      rdata_q     <= '0;
      rdata_en_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      rdata_en_q  <= beat;
      rd_err_q    <= rd_err_d;
      if (beat) begin
        rdata_q <= axi_rdata;
      end
    end
  end

  assign axi_arvalid  = (state_q == StAddr);
  assign axi_araddr   = cur_addr_q;
  assign axi_arlen    = (state_q == StAddr) ? 8'(burst_beats - BW'(1)) : 8'd0;
  assign axi_rready   = (state_q == StData);
  assign ddr_rdone    = (state_q == StDone);
  assign ddr_rdata    = rdata_q;
  assign ddr_rdata_en = rdata_en_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// Directed bench for ddr_rd_ctrl: a small AXI read slave plus an output monitor that
// checks every forwarded beat against a queue of expected data.
module tb_ddr_rd_ctrl;

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          ddr_rstn;
  logic          init_done;
  logic          ddr_rreq;
  logic [AW-1:0] ddr_raddr;
  logic [15:0]   ddr_rd_len;
  logic          ddr_rrdy, ddr_rdone, ddr_rdata_en, rd_err;
  logic [DW-1:0] ddr_rdata;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid, axi_arready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid, axi_rlast, axi_rready;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int ar_hs_cnt = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  ddr_rd_ctrl dut (
    .ddr_clk      (clk),
    .ddr_rstn     (ddr_rstn),
    .init_done    (init_done),
    .ddr_rreq     (ddr_rreq),
    .ddr_raddr    (ddr_raddr),
    .ddr_rd_len   (ddr_rd_len),
    .ddr_rrdy     (ddr_rrdy),
    .ddr_rdone    (ddr_rdone),
    .ddr_rdata    (ddr_rdata),
    .ddr_rdata_en (ddr_rdata_en),
    .rd_err       (rd_err),
    .axi_araddr   (axi_araddr),
    .axi_arlen    (axi_arlen),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rvalid   (axi_rvalid),
    .axi_rlast    (axi_rlast),
    .axi_rready   (axi_rready)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ddr_rdata_en) begin
      en_cnt++;
      if (exp_q.size() == 0) check("rdata_unexpected", 1'b1, 1'b0);
      else check("rdata", ddr_rdata, exp_q.pop_front());
    end
    if (ddr_rdone) done_cnt++;
    if (axi_arvalid && axi_arready) ar_hs_cnt++;
  end

  task automatic issue(input int addr, input int len);
    check("rrdy_before_req", ddr_rrdy, 1'b1);
    ddr_raddr  = AW'(addr);
    ddr_rd_len = 16'(len);
    ddr_rreq   = 1'b1;
    tick();
    ddr_rreq = 1'b0;
  endtask

  task automatic ar_phase(input int addr, input int len, input int delay, input bit poke);
    int n = 0;
    while (!axi_arvalid && n < 20) begin
      tick();
      n++;
    end
    check("arvalid", axi_arvalid, 1'b1);
    check("araddr", axi_araddr, addr);
    check("arlen", axi_arlen, len - 1);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 3) begin
        ddr_raddr  = AW'('h999);
        ddr_rd_len = 16'd5;
        ddr_rreq   = 1'b1;
      end
      if (poke && i == 5) init_done = 1'b0;
      if (poke && i == 8) init_done = 1'b1;
      tick();
      ddr_rreq = 1'b0;
      check("ar_hold_valid", axi_arvalid, 1'b1);
      check("ar_hold_addr", axi_araddr, addr);
      check("ar_hold_len", axi_arlen, len - 1);
    end
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    check("arvalid_drop", axi_arvalid, 1'b0);
    check("rready_data", axi_rready, 1'b1);
  endtask

  task automatic r_beats(input int n, input int rlast_at, input int base);
    for (int i = 0; i < n; i++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = {8{32'(base + i)}};
      axi_rlast  = (i == rlast_at);
      exp_q.push_back(axi_rdata);
      tick();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, h0;
    ddr_rstn = 1'b0; init_done = 1'b1; ddr_rreq = 1'b0; ddr_raddr = '0; ddr_rd_len = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #3;
    check("rst_rrdy", ddr_rrdy, 1'b0);
    check("rst_arvalid", axi_arvalid, 1'b0);
    check("rst_arlen", axi_arlen, 0);
    check("rst_rready", axi_rready, 1'b0);
    check("rst_rdone", ddr_rdone, 1'b0);
    tick();
    tick();
    ddr_rstn = 1'b1;
    init_done = 1'b0;
    tick();
    check("no_init_rrdy", ddr_rrdy, 1'b0);
    ddr_rreq = 1'b1;
    tick();
    ddr_rreq = 1'b0;
    check("no_init_ignored", axi_arvalid, 1'b0);
    tick();
    check("no_init_no_done", ddr_rdone, 1'b0);
    init_done = 1'b1;
    #1;
    check("init_rrdy", ddr_rrdy, 1'b1);

    // A: single 4-beat burst
    e0 = en_cnt; d0 = done_cnt;
    issue('h100, 4);
    check("a_arvalid_latency", axi_arvalid, 1'b1);
    ar_phase('h100, 4, 0, 1'b0);
    r_beats(4, 3, 'hA0);
    check("a_done", ddr_rdone, 1'b1);
    check("a_done_with_en", ddr_rdata_en, 1'b1);
    tick();
    check("a_en_count", en_cnt - e0, 4);
    check("a_done_count", done_cnt - d0, 1);
    check("a_rrdy_back", ddr_rrdy, 1'b1);
    check("a_err", rd_err, 1'b0);

    // B: 40 beats -> 16 + 16 + 8
    e0 = en_cnt; d0 = done_cnt;
    issue('h0, 40);
    for (int b = 0; b < 3; b++) begin
      ar_phase(b * 'h80, (b < 2) ? 16 : 8, 0, 1'b0);
      r_beats((b < 2) ? 16 : 8, (b < 2) ? 15 : 7, 'h1000 + b * 16);
      if (b < 2) check("b_no_early_done", ddr_rdone, 1'b0);
    end
    check("b_done", ddr_rdone, 1'b1);
    check("b_done_with_en", ddr_rdata_en, 1'b1);
    tick();
    check("b_en_count", en_cnt - e0, 40);
    check("b_done_count", done_cnt - d0, 1);
    check("b_err", rd_err, 1'b0);

    // C: zero-length request
    h0 = ar_hs_cnt;
    issue('h50, 0);
    check("c_done", ddr_rdone, 1'b1);
    check("c_no_arvalid", axi_arvalid, 1'b0);
    check("c_rrdy_busy", ddr_rrdy, 1'b0);
    tick();
    check("c_rrdy_back", ddr_rrdy, 1'b1);
    check("c_done_drop", ddr_rdone, 1'b0);
    check("c_no_burst", ar_hs_cnt - h0, 0);

    // D: slow arready, busy re-request, init_done glitch mid-transfer
    e0 = en_cnt; d0 = done_cnt; h0 = ar_hs_cnt;
    issue('h200, 8);
    ar_phase('h200, 8, 10, 1'b1);
    r_beats(8, 7, 'h3000);
    check("d_done", ddr_rdone, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("d_en_count", en_cnt - e0, 8);
    check("d_done_count", done_cnt - d0, 1);
    check("d_one_burst", ar_hs_cnt - h0, 1);
    check("d_idle_no_arvalid", axi_arvalid, 1'b0);

    // E: early rlast
    e0 = en_cnt; d0 = done_cnt;
    issue('h300, 4);
    ar_phase('h300, 4, 0, 1'b0);
    r_beats(4, 1, 'h4000);
    check("e_done", ddr_rdone, 1'b1);
    check("e_err", rd_err, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("e_en_count", en_cnt - e0, 4);
    check("e_done_count", done_cnt - d0, 1);
    check("e_err_sticky", rd_err, 1'b1);

    // F: reset during beat 3 of 16
    issue('h400, 16);
    ar_phase('h400, 16, 0, 1'b0);
    r_beats(2, 15, 'h5000);
    axi_rvalid = 1'b1;
    axi_rdata  = {8{32'h5002}};
    ddr_rstn   = 1'b0;
    #1;
    check("f_rdata_en", ddr_rdata_en, 1'b0);
    check("f_rdata", ddr_rdata, 0);
    check("f_err", rd_err, 1'b0);
    check("f_araddr", axi_araddr, 0);
    check("f_arlen", axi_arlen, 0);
    check("f_rready", axi_rready, 1'b0);
    check("f_rrdy", ddr_rrdy, 1'b0);
    check("f_rdone", ddr_rdone, 1'b0);
    axi_rvalid = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    tick();
    tick();
    ddr_rstn = 1'b1;
    tick();
    check("f_rrdy_after", ddr_rrdy, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("f_no_done", done_cnt - d0, 0);
    check("f_idle_arvalid", axi_arvalid, 1'b0);
    check("f_err_after", rd_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
